// File: rtl/click_pkg.sv
// Shared types and defaults for the click arbiter.
//   db_state_e : per-button debounce FSM states
//   grant_e    : arbiter grant encoding
//   DEF_*      : default parameter values
//   stab_w()   : stability counter width for a given debounce length
package click_pkg;

    localparam int unsigned DEF_CNT_W     = 8;
    localparam int unsigned DEF_DB_CYCLES = 120000;

    typedef enum logic [1:0] {
        DB_RELEASED,
        DB_PRESS_WAIT,
        DB_PRESSED,
        DB_RELEASE_WAIT
    } db_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_UP,
        GNT_DN
    } grant_e;

    // clog2 of the debounce length, never narrower than one bit
    function automatic int unsigned stab_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a debounce FSM for one raw button.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   btn   : raw asynchronous, bouncy button (1 = pressed)
//   click : registered one-cycle pulse when a press is accepted
module button_debounce
    import click_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic click
);

    localparam int unsigned   SW   = stab_w(DB_CYCLES);
    localparam logic [SW-1:0] LAST = SW'(DB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    db_state_e     state;
    db_state_e     state_nxt;
    logic [SW-1:0] stab;
    logic [SW-1:0] stab_nxt;
    logic          click_nxt;

    // synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    // state, stability counter and click register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DB_RELEASED;
            stab  <= '0;
            click <= 1'b0;
        end else begin
            state <= state_nxt;
            stab  <= stab_nxt;
            click <= click_nxt;
        end
    end

    // next-state: any opposite sample in a wait state is a bounce and aborts
    always_comb begin
        state_nxt = state;
        stab_nxt  = stab;
        click_nxt = 1'b0;
        case (state)
            DB_RELEASED: begin
                if (sync_b) begin
                    state_nxt = DB_PRESS_WAIT;
                    stab_nxt  = '0;
                end
            end
            DB_PRESS_WAIT: begin
                if (!sync_b) begin
                    state_nxt = DB_RELEASED;
                    stab_nxt  = '0;
                end else if (stab == LAST) begin
                    state_nxt = DB_PRESSED;
                    stab_nxt  = '0;
                    click_nxt = 1'b1;
                end else begin
                    stab_nxt = stab + SW'(1);
                end
            end
            DB_PRESSED: begin
                if (!sync_b) begin
                    state_nxt = DB_RELEASE_WAIT;
                    stab_nxt  = '0;
                end
            end
            DB_RELEASE_WAIT: begin
                if (sync_b) begin
                    state_nxt = DB_PRESSED;
                    stab_nxt  = '0;
                end else if (stab == LAST) begin
                    state_nxt = DB_RELEASED;
                    stab_nxt  = '0;
                end else begin
                    stab_nxt = stab + SW'(1);
                end
            end
            default: begin
                state_nxt = DB_RELEASED;
                stab_nxt  = '0;
            end
        endcase
    end

endmodule

// File: rtl/click_arbiter.sv
// Two debounced buttons share one up/down counter through a round-robin arbiter.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   btn_up : raw increment button
//   btn_dn : raw decrement button
//   cnt    : shared counter (registered)
//   wrap   : one-cycle pulse while cnt shows a wrapped value
//   busy   : high while either request is pending
module click_arbiter
    import click_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_dn,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             click_up;
    logic             click_dn;
    logic             pend_up;
    logic             pend_dn;
    logic             pend_up_nxt;
    logic             pend_dn_nxt;
    grant_e           grant;
    grant_e           last_grant;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wrap_nxt;

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_up),
        .click (click_up)
    );

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_dn),
        .click (click_dn)
    );

    // grant selection, pending update (a new click beats a same-cycle clear), counter math
    always_comb begin
        grant    = GNT_NONE;
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        if (pend_up && pend_dn) begin
            grant = (last_grant == GNT_UP) ? GNT_DN : GNT_UP;
        end else if (pend_up) begin
            grant = GNT_UP;
        end else if (pend_dn) begin
            grant = GNT_DN;
        end

        pend_up_nxt = click_up | (pend_up & (grant != GNT_UP));
        pend_dn_nxt = click_dn | (pend_dn & (grant != GNT_DN));

        case (grant)
            GNT_UP: begin
                cnt_nxt  = cnt + CNT_W'(1);
                wrap_nxt = (cnt == CNT_MAX);
            end
            GNT_DN: begin
                cnt_nxt  = cnt - CNT_W'(1);
                wrap_nxt = (cnt == '0);
            end
            default: ;
        endcase
    end

    // registered counter, flags and status
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            wrap       <= 1'b0;
            busy       <= 1'b0;
            pend_up    <= 1'b0;
            pend_dn    <= 1'b0;
            last_grant <= GNT_DN;
        end else begin
            cnt     <= cnt_nxt;
            wrap    <= wrap_nxt;
            pend_up <= pend_up_nxt;
            pend_dn <= pend_dn_nxt;
            busy    <= pend_up_nxt | pend_dn_nxt;
            if (grant != GNT_NONE) begin
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_click_arbiter.sv
// Scoreboard bench for click_arbiter with DB_CYCLES=4, CNT_W=8.
// Stimulus pushes expected counter changes (value, wrap, cycle); a monitor
// pops and compares each time cnt changes outside reset.
module tb_click_arbiter;

    localparam int unsigned DB = 4;
    localparam int unsigned CW = 8;

    typedef struct {
        logic [CW-1:0] c;
        logic          w;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_up;
    logic          btn_dn;
    logic [CW-1:0] cnt;
    logic          wrap;
    logic          busy;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    int   mc      = 0;
    bit   last_up = 1'b0;

    click_arbiter #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_up (btn_up),
        .btn_dn (btn_dn),
        .cnt    (cnt),
        .wrap   (wrap),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // model of one granted operation
    task automatic push_op(input bit up, input int at);
        exp_t e;
        if (up) begin
            e.w     = (mc == 255);
            mc      = (mc + 1) % 256;
            last_up = 1'b1;
        end else begin
            e.w     = (mc == 0);
            mc      = (mc + 255) % 256;
            last_up = 1'b0;
        end
        e.c   = CW'(mc);
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    // steady press of one or both buttons, then release and let it settle
    task automatic press(input bit up, input bit dn, input string tag);
        int t0;
        bit tie;
        bit first_up;
        @(negedge clk);
        btn_up = up;
        btn_dn = dn;
        t0     = cyc;
        tie    = up && dn;
        if (tie) begin
            first_up = !last_up;
            push_op(first_up, t0 + 9);
            push_op(!first_up, t0 + 10);
        end else begin
            push_op(up, t0 + 9);
        end
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 7)  chk({tag, "_busy_before"}, busy, 0);
            if (n == 8)  chk({tag, "_busy_first"}, busy, 1);
            if (n == 9)  chk({tag, "_busy_second"}, busy, tie ? 1 : 0);
            if (n == 10) chk({tag, "_busy_after"}, busy, 0);
        end
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst     = 1'b0;
        mc      = 0;
        last_up = 1'b0;
    endtask

    // monitor: every cnt change must match the head of the scoreboard
    logic [CW-1:0] prev_cnt;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_cnt = cnt;
        end else if (cnt !== prev_cnt) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cnt_change", cnt, prev_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cnt_value", cnt, e.c);
                chk("cnt_wrap", wrap, e.w);
                chk("cnt_cycle", cyc, e.cyc);
            end
            prev_cnt = cnt;
        end else begin
            chk("wrap_idle", wrap, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        rst    = 1'b1;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cnt", cnt, 0);
        chk("reset_wrap", wrap, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // steady press, single increment while held
        press(1'b1, 1'b0, "steady_up");

        // bouncing press: 1,0,1,0 then steady 1
        @(negedge clk); btn_up = 1'b1;
        @(negedge clk); btn_up = 1'b0;
        @(negedge clk); btn_up = 1'b1;
        @(negedge clk); btn_up = 1'b0;
        @(negedge clk); btn_up = 1'b1;
        t1 = cyc;
        push_op(1'b1, t1 + 9);
        repeat (16) @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);

        // reach 5 with dn granted last
        press(1'b1, 1'b0, "up3");
        press(1'b1, 1'b0, "up4");
        press(1'b1, 1'b0, "up5");
        press(1'b1, 1'b0, "up6");
        press(1'b0, 1'b1, "dn5");
        chk("pre_tie_cnt", cnt, 5);

        // tie: up first, then dn
        press(1'b1, 1'b1, "tie1");
        // up grant, then repeat tie: dn first
        press(1'b1, 1'b0, "up_mid");
        press(1'b1, 1'b1, "tie2");

        // wrap in both directions
        do_reset(2);
        press(1'b0, 1'b1, "dn_wrap_a");
        chk("wrap_low_cnt", cnt, 255);
        press(1'b1, 1'b0, "up_wrap");
        press(1'b0, 1'b1, "dn_wrap_b");

        // reset mid PRESS_WAIT with btn_up held
        @(negedge clk);
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        mc      = 0;
        last_up = 1'b0;
        t1      = cyc;
        chk("mid_reset_cnt", cnt, 0);
        chk("mid_reset_busy", busy, 0);
        push_op(1'b1, t1 + 9);
        repeat (16) @(negedge clk);
        btn_up = 1'b0;
        repeat (20) @(negedge clk);

        chk("queue_drained", exp_q.size(), 0);
        chk("final_cnt", cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/click_arbiter.md
CLICK_ARBITER -- requirements
Module: click_arbiter

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 120000, meaning consecutive stable cycles required to accept a button level change (10 ms at 12 MHz).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the shared counter.
REQ-003 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port btn_up  input  1  raw increment button, asynchronous, active-high (1 = pressed), bouncy.
REQ-006 SHALL have port btn_dn  input  1  raw decrement button, asynchronous, active-high (1 = pressed), bouncy.
REQ-007 SHALL have port cnt  output  CNT_W  shared counter value, driven from a register.
REQ-008 SHALL have port wrap  output  1  one-cycle pulse on counter wrap-around.
REQ-009 SHALL have port busy  output  1  high while either request is pending.

Function
REQ-010 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-011 SHALL run one debounce FSM per button: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 SHALL move RELEASED->PRESS_WAIT on synced=1 and RELEASE_WAIT... PRESSED->RELEASE_WAIT on synced=0, clearing the stability counter.
REQ-013 SHALL return PRESS_WAIT->RELEASED, or RELEASE_WAIT->PRESSED, on any opposite sample (bounce), clearing the counter.
REQ-014 SHALL enter PRESSED from PRESS_WAIT, or RELEASED from RELEASE_WAIT, when the counter reaches DB_CYCLES-1 with the level unchanged.
REQ-015 SHALL emit a one-cycle click pulse, registered, only on entry to PRESSED; release produces no event.
REQ-016 SHALL hold a pending flag per button, set by its click pulse and cleared when granted.
REQ-017 SHALL grant at most one request per cycle and apply the grant to cnt on the following edge.
REQ-018 SHALL, with both flags pending, grant the button not granted last (round-robin); last_grant resets to dn so up wins the first tie.
REQ-019 SHALL serve the loser of a tie exactly one cycle after the winner; no click is ever dropped.
REQ-020 SHALL, for a grant that sets a flag and clears it in the same cycle, leave the flag set (new event wins).
REQ-021 SHALL increment on an up grant with wrap (2^CNT_W-1 -> 0) and decrement on a dn grant with wrap (0 -> 2^CNT_W-1); modulo-2^CNT_W arithmetic.
REQ-022 SHALL pulse wrap for exactly the cycle in which cnt shows the wrapped value.
REQ-023 SHALL give a fixed latency: with btn held steadily high from its first sampling edge, cnt changes at edge DB_CYCLES+4 (sync 2, debounce DB_CYCLES, pulse 1, grant 1), uncontended.
REQ-024 SHALL drive busy = pend_up | pend_dn.

Reset
REQ-025 SHALL, when rst=1 at an edge, set cnt=0, wrap=0, busy=0, pending flags=0, synchronizers=0, FSMs=RELEASED, stability counters=0, last_grant=dn.
REQ-026 SHALL let rst override any same-cycle grant, click pulse or debounce transition.
REQ-027 SHALL abandon an in-progress debounce on reset; a button still held after reset is a fresh press, accepted after full latency.

Structure
REQ-028 SHALL place in shared package click_pkg: debounce state enum, grant encoding (NONE/UP/DN), default CNT_W and DB_CYCLES constants.
REQ-029 SHALL implement sync plus debounce FSM as sub-module button_debounce (ports clk, rst, btn, click), instantiated twice.
REQ-030 SHALL size each stability counter as clog2(DB_CYCLES) bits.

Verification (DB_CYCLES=4, CNT_W=8)
REQ-031 SHALL check: btn_up high steady from edge 0 -> cnt 0->1 at edge 8, wrap=0, single increment while held.
REQ-032 SHALL check: btn_up bounces 1,0,1,0 then steady 1 -> exactly one increment, 8 edges after the final rise.
REQ-033 SHALL check: btn_up and btn_dn rise same edge from cnt=5 -> cnt 6 then 5 on consecutive cycles, busy high 2 cycles; repeat tie -> dn served first.
REQ-034 SHALL check: cnt=255 plus up click -> cnt=0, wrap=1 for one cycle; then dn click -> cnt=255, wrap=1.
REQ-035 SHALL check: rst pulsed mid-PRESS_WAIT with btn_up held -> cnt=0, no click; increment 8 edges after rst release.
